// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ADD/SUB/AND/OR/SRL/SLL plus a shift-add MULTU
// that produces a 2*WIDTH product. Results and flags are registered and held until taken.
module alu_seq #(
  parameter  int WIDTH   = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   src1,
  input  logic [WIDTH-1:0]   src2,
  input  logic [5:0]         funct,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic [WIDTH-1:0]   hi,
  output logic               zero,
  output logic               carry
);

  localparam logic [5:0] F_ADD   = 6'd27;
  localparam logic [5:0] F_SUB   = 6'd28;
  localparam logic [5:0] F_AND   = 6'd29;
  localparam logic [5:0] F_OR    = 6'd30;
  localparam logic [5:0] F_SRL   = 6'd31;
  localparam logic [5:0] F_SLL   = 6'd32;
  localparam logic [5:0] F_MULTU = 6'd33;
  localparam logic [SHAMT_W:0] MUL_LAST = (SHAMT_W+1)'(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t             state;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mcand;
  logic [SHAMT_W:0]   count;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic [WIDTH:0]     add_w;
  logic [WIDTH:0]     sub_w;
  logic [WIDTH:0]     srl_w;
  logic [WIDTH:0]     sll_w;
  logic               accept;

  assign in_ready = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  // Single-cycle datapath; the extra low bit of srl_w catches the last bit shifted out.
  always_comb begin
    add_w     = {1'b0, src1} + {1'b0, src2};
    sub_w     = {1'b0, src1} - {1'b0, src2};
    srl_w     = {src1, 1'b0} >> shamt;
    sll_w     = {1'b0, src1} << shamt;
    alu_res   = src2;
    alu_carry = 1'b0;
    case (funct)
      F_ADD: begin
        alu_res   = add_w[WIDTH-1:0];
        alu_carry = add_w[WIDTH];
      end
      F_SUB: begin
        alu_res   = sub_w[WIDTH-1:0];
        alu_carry = sub_w[WIDTH];
      end
      F_AND: alu_res = src1 & src2;
      F_OR:  alu_res = src1 | src2;
      F_SRL: begin
        alu_res   = srl_w[WIDTH:1];
        alu_carry = srl_w[0];
      end
      F_SLL: begin
        alu_res   = sll_w[WIDTH-1:0];
        alu_carry = sll_w[WIDTH];
      end
      default: begin
        alu_res   = src2;
        alu_carry = 1'b0;
      end
    endcase
  end

  // One shift-add step: conditionally add the multiplicand into the upper half.
  always_comb begin
    if (prod[0]) begin
      mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
    end else begin
      mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]};
    end
  end

  // Control FSM and registered result/flag outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      result    <= {WIDTH{1'b0}};
      hi        <= {WIDTH{1'b0}};
      zero      <= 1'b0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
      prod      <= {(2*WIDTH){1'b0}};
      mcand     <= {WIDTH{1'b0}};
      count     <= {(SHAMT_W+1){1'b0}};
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (funct == F_MULTU) begin
              state     <= MUL;
              out_valid <= 1'b0;
              mcand     <= src1;
              prod      <= {{WIDTH{1'b0}}, src2};
              count     <= {(SHAMT_W+1){1'b0}};
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              result    <= alu_res;
              hi        <= {WIDTH{1'b0}};
              zero      <= (alu_res == {WIDTH{1'b0}});
              carry     <= alu_carry;
            end
          end else if ((state == DONE) && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        MUL: begin
          // The extra cycle after the last step publishes the product.
          if (count == MUL_LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= prod[WIDTH-1:0];
            hi        <= prod[2*WIDTH-1:WIDTH];
            zero      <= (prod[WIDTH-1:0] == {WIDTH{1'b0}});
            carry     <= (prod[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
          end else begin
            prod  <= {mul_sum, prod[WIDTH-1:1]};
            count <= count + {{SHAMT_W{1'b0}}, 1'b1};
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
